// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, IMEM/BIOS source select and bubble insertion.
// Build option FETCH_BIOS_EN enables the BIOS region (pc[31:28]==4'h4) as an instruction source.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h4000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [13:0] imem_addr,
  input  logic [31:0] imem_dout,
  output logic [11:0] bios_addr,
  input  logic [31:0] bios_dout,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic [31:0] fetch_cnt
);

  // state | meaning
  // FIRST | just out of reset; memory is still loading the word at RESET_PC
  // RUN   | memory read data corresponds to pc_q
  typedef enum logic {
    FIRST = 1'b0,
    RUN   = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] next_pc;
  logic [31:0] src_word;
  logic        src_ok;
  logic        accept;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FIRST;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: FIRST lasts exactly one edge, RUN holds until reset
  always_comb begin
    state_d = state_q;
    case (state_q)
      FIRST:   state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = FIRST;
    endcase
  end

  // Output logic
  always_comb begin
    instr_valid = 1'b0;
    instr       = NOP_INSTR;
    if ((state_q == RUN) && !redirect && src_ok) begin
      instr_valid = 1'b1;
      instr       = src_word;
    end
  end

  // Next PC; FIRST keeps the reset address so the preloaded word is re-read
  always_comb begin
    next_pc = pc_q + 32'd4;
    if (state_q == FIRST) begin
      next_pc = RESET_PC;
    end else if (redirect) begin
      next_pc = {redirect_pc[31:2], 2'b00};
    end else if (stall) begin
      next_pc = pc_q;
    end
  end

  // Region decode on the PC whose data is on the memory outputs this cycle
  always_comb begin
    src_word = NOP_INSTR;
    src_ok   = 1'b0;
    if (pc_q[31:28] == 4'h1) begin
      src_word = imem_dout;
      src_ok   = 1'b1;
    end
`ifdef FETCH_BIOS_EN
    else if (pc_q[31:28] == 4'h4) begin
      src_word = bios_dout;
      src_ok   = 1'b1;
    end
`endif
  end

  assign accept      = instr_valid & ~stall;
  assign pc_d        = next_pc;
  assign fetch_cnt_d = fetch_cnt_q + {31'd0, accept};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      fetch_cnt_q <= 32'd0;
    end else begin
      pc_q        <= pc_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign imem_addr = next_pc[15:2];
`ifdef FETCH_BIOS_EN
  assign bios_addr = next_pc[13:2];
  logic unused_bits;
  assign unused_bits = ^redirect_pc[1:0];
`else
  assign bios_addr = 12'd0;
  logic unused_bits;
  assign unused_bits = ^{bios_dout, redirect_pc[1:0]};
`endif

  assign instr_pc  = pc_q;
  assign fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: driver queues expected per-cycle outputs, monitor compares mid-cycle.
module tb_fetch_stage;
`ifdef FETCH_BIOS_EN
  localparam bit          BIOS_EN = 1'b1;
  localparam logic [31:0] B       = 32'h4000_0000;
`else
  localparam bit          BIOS_EN = 1'b0;
  localparam logic [31:0] B       = 32'h1000_0000;
`endif
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] CNT8B = 32'd8 + {31'd0, BIOS_EN};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [13:0] imem_addr;
  logic [31:0] imem_dout;
  logic [11:0] bios_addr;
  logic [31:0] bios_dout;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic [31:0] fetch_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    logic        v;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] cnt;
    logic [13:0] ia;
    logic [11:0] ba;
  } exp_t;

  exp_t exp_q[$];
  event probe_ev;

  fetch_stage #(.RESET_PC(B), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_dout(imem_dout),
    .bios_addr(bios_addr), .bios_dout(bios_dout), .instr(instr),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [13:0] a);
    return 32'hA000_0000 | {18'd0, a};
  endfunction

  function automatic logic [31:0] bios_word(input logic [11:0] a);
    return 32'h0000_0093 | {a, 20'd0};
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    if (pc[31:28] == 4'h1) return imem_word(pc[15:2]);
    if (BIOS_EN && pc[31:28] == 4'h4) return bios_word(pc[13:2]);
    return NOP;
  endfunction

  // Synchronous-read memories, one cycle address-to-data
  always @(posedge clk) begin
    imem_dout <= imem_word(imem_addr);
    bios_dout <= bios_word(bios_addr);
  end

  task automatic expect_cycle(input logic v, input logic [31:0] pc,
                              input logic [31:0] cnt, input logic [31:0] nxt);
    exp_t e;
    e.v     = v;
    e.instr = v ? word_at(pc) : NOP;
    e.pc    = pc;
    e.cnt   = cnt;
    e.ia    = nxt[15:2];
    e.ba    = BIOS_EN ? nxt[13:2] : 12'd0;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] rpc,
                      input logic v, input logic [31:0] pc, input logic [31:0] cnt,
                      input logic [31:0] nxt);
    rst_n = r; stall = s; redirect = rd; redirect_pc = rpc;
    expect_cycle(v, pc, cnt, nxt);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares one queued expectation per mid-cycle sample or async probe
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or probe_ev);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, e.v});
        chk("instr", instr, e.instr);
        chk("instr_pc", instr_pc, e.pc);
        chk("fetch_cnt", fetch_cnt, e.cnt);
        chk("imem_addr", {18'd0, imem_addr}, {18'd0, e.ia});
        chk("bios_addr", {20'd0, bios_addr}, {20'd0, e.ba});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    // held in reset
    step(0, 0, 0, 0, 0, B, 0, B);
    step(0, 1, 1, 32'h1000_0100, 0, B, 0, B);
    // release: FIRST then free run
    step(1, 0, 0, 0, 0, B,            0, B);
    step(1, 0, 0, 0, 1, B,            0, B + 32'h4);
    step(1, 0, 0, 0, 1, B + 32'h4,    1, B + 32'h8);
    step(1, 0, 0, 0, 1, B + 32'h8,    2, B + 32'hC);
    step(1, 0, 0, 0, 1, B + 32'hC,    3, B + 32'h10);
    step(1, 0, 0, 0, 1, B + 32'h10,   4, B + 32'h14);
    // redirect back to B+8, then stall there 3 cycles
    step(1, 0, 1, B + 32'h8, 0, B + 32'h14, 5, B + 32'h8);
    step(1, 1, 0, 0, 1, B + 32'h8, 5, B + 32'h8);
    step(1, 1, 0, 0, 1, B + 32'h8, 5, B + 32'h8);
    step(1, 1, 0, 0, 1, B + 32'h8, 5, B + 32'h8);
    step(1, 0, 0, 0, 1, B + 32'h8, 5, B + 32'hC);
    // unaligned redirect target lands on imem word 4
    step(1, 0, 1, 32'h1000_0013, 0, B + 32'hC, 6, 32'h1000_0010);
    step(1, 0, 0, 0, 1, 32'h1000_0010, 6, 32'h1000_0014);
    // redirect and stall together: redirect wins
    step(1, 1, 1, 32'h1000_0040, 0, 32'h1000_0014, 7, 32'h1000_0040);
    step(1, 1, 0, 0, 1, 32'h1000_0040, 7, 32'h1000_0040);
    step(1, 0, 0, 0, 1, 32'h1000_0040, 7, 32'h1000_0044);
    // unmapped region produces bubbles
    step(1, 0, 1, 32'h2000_0000, 0, 32'h1000_0044, 8, 32'h2000_0000);
    step(1, 0, 0, 0, 0, 32'h2000_0000, 8, 32'h2000_0004);
    // BIOS region: valid only when the BIOS source is built in
    step(1, 0, 1, 32'h4000_0100, 0, 32'h2000_0004, 8, 32'h4000_0100);
    step(1, 0, 0, 0, BIOS_EN, 32'h4000_0100, 8, 32'h4000_0104);
    step(1, 0, 1, 32'h1000_0020, 0, 32'h4000_0104, CNT8B, 32'h1000_0020);
    // async reset in the middle of a stall
    rst_n = 1; stall = 1; redirect = 0; redirect_pc = 0;
    expect_cycle(1, 32'h1000_0020, CNT8B, 32'h1000_0020);
    @(negedge clk);
    #2;
    rst_n = 0;
    #1;
    expect_cycle(0, B, 0, B);
    ->probe_ev;
    @(posedge clk); #1;
    step(0, 1, 0, 0, 0, B, 0, B);
    step(1, 0, 0, 0, 0, B, 0, B);
    step(1, 0, 0, 0, 1, B, 0, B + 32'h4);
    // preset the counter to all-ones; the next accept wraps it
    rst_n = 1; stall = 0; redirect = 0; redirect_pc = 0;
    force dut.fetch_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_cnt_q;
    expect_cycle(1, B + 32'h4, 32'hFFFF_FFFF, B + 32'h8);
    @(posedge clk); #1;
    step(1, 0, 0, 0, 1, B + 32'h8, 0, B + 32'hC);
    step(1, 0, 0, 0, 1, B + 32'hC, 1, B + 32'h10);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h4000_0000, first fetch address after reset (BIOS base).
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), the bubble instruction driven to decode.
REQ-003 clk  in  1  single clock; every register updates on the rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 stall  in  1  downstream cannot accept; hold the current fetch.
REQ-006 redirect  in  1  branch/jump taken; squash the current instruction and refetch.
REQ-007 redirect_pc  in  32  redirect target; bits [1:0] ignored.
REQ-008 imem_addr  out  14  IMEM word address, equal to next_pc[15:2].
REQ-009 imem_dout  in  32  IMEM read data, valid one cycle after the address.
REQ-010 bios_addr  out  12  BIOS word address, equal to next_pc[13:2].
REQ-011 bios_dout  in  32  BIOS read data, valid one cycle after the address.
REQ-012 instr  out  32  instruction to the decode stage.
REQ-013 instr_pc  out  32  address of instr, equal to pc_q.
REQ-014 instr_valid  out  1  instr is a real, non-squashed instruction.
REQ-015 fetch_cnt  out  32  count of instructions accepted by downstream.

Function
REQ-016 pc_q is a 32-bit register; next_pc is combinational with priority: redirect -> {redirect_pc[31:2],2'b00}; else stall -> pc_q; else pc_q+4 (mod 2^32).
REQ-017 Both memory addresses always come from next_pc, so read data in a cycle corresponds to pc_q, and a stall re-reads the same word to keep instr stable.
REQ-018 Two-state FSM: FIRST (after reset; memory data not yet valid) -> RUN on the first clock edge, with RUN held until reset.
REQ-019 Source select uses pc_q: pc_q[31:28]==4'h4 selects bios_dout; pc_q[31:28]==4'h1 selects imem_dout; any other region gives instr=NOP_INSTR and instr_valid=0.
REQ-020 instr_valid = (state==RUN) & ~redirect & address in a valid region; when instr_valid=0, instr = NOP_INSTR.
REQ-021 Redirect in cycle N: instr/instr_valid in cycle N are squashed; in cycle N+1, instr_pc = target and instr = mem[target].
REQ-022 Redirect and stall in the same cycle: redirect wins, so the PC moves to the target.
REQ-023 fetch_cnt increments by 1 on each edge where instr_valid & ~stall, wrapping from 32'hFFFF_FFFF to 0.
REQ-024 Latency: one cycle from address to instr, with a throughput of one instruction per cycle when stall=0.

Reset
REQ-025 While rst_n=0: pc_q=RESET_PC, state=FIRST, fetch_cnt=0, instr=NOP_INSTR, instr_valid=0, and next_pc=RESET_PC so that memory preloads the first word.
REQ-026 Reset asserted mid-stall or mid-redirect discards all pending state immediately and asynchronously.
REQ-027 On the first edge after rst_n rises: pc_q stays RESET_PC (next_pc equals RESET_PC in FIRST) and state becomes RUN; the next cycle presents mem[RESET_PC] with valid=1.

Configuration
REQ-028 Macro FETCH_BIOS_EN: when defined, behaviour is as in REQ-019.
REQ-029 Without FETCH_BIOS_EN: bios_addr is tied to 0, bios_dout is ignored, and the 4'h4 region is treated as invalid; the default RESET_PC must then be overridden to an IMEM address by the instantiator.

Verification
REQ-030 Reset release, BIOS word 0 = 32'h0000_0093 -> cycle 1 instr=32'h0000_0093, instr_pc=32'h4000_0000, valid=1; cycle 0 valid=0.
REQ-031 Free run for 5 cycles -> instr_pc = 4000_0000, 4000_0004, ..., 4000_0010, and fetch_cnt=5.
REQ-032 stall held 3 cycles at instr_pc=32'h4000_0008 -> instr/instr_pc constant, and fetch_cnt does not advance.
REQ-033 redirect with redirect_pc=32'h1000_0013 -> same cycle instr=NOP_INSTR and valid=0; next cycle instr_pc=32'h1000_0010 and instr=imem word 4.
REQ-034 redirect+stall together -> the PC still moves to the target; redirect to 32'h2000_0000 -> instr=NOP_INSTR and valid=0 until the next redirect.
REQ-035 rst_n pulsed low mid-stall -> outputs go to reset values asynchronously; preset fetch_cnt=32'hFFFF_FFFF plus one accept -> wraps to 0.
